ppu_fb_writer: RTL

PPU_FB_WRITER -- requirements
Module: ppu_fb_writer

---
 rtl/ppu_fb_writer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/ppu_fb_writer.sv
// rtl/ppu_fb_writer.sv - PPU pixel capture into a 2-bank line buffer, emitted 3x/2x scaled as RGB565 framebuffer writes
`timescale 1ns/1ps

module ppu_fb_writer #(
  parameter logic [23:0] BASE  = 24'hf00000,
  parameter int          WIDTH = 800,
  parameter int          HOFF  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        pix_we,
  input  logic [8:0]  pix_x,
  input  logic [8:0]  pix_y,
  input  logic [23:0] pix_rgb,
  output logic        out_we,
  input  logic        out_rdy,
  output logic [23:0] out_addr,
  output logic [15:0] out_data,
  output logic        frame,
  output logic        overrun,
  input  logic        clr
);

  typedef enum logic [1:0] {IDLE, LOAD, FETCH, EMIT} state_t;

  localparam logic [23:0] STRIDE = 24'(2 * WIDTH);
  localparam logic [23:0] PITCH  = 24'(WIDTH);
  localparam logic [23:0] MARGIN = 24'(HOFF);

  state_t          state_q, state_d;
  logic            wbank_q, wbank_d;
  logic            rbank_q, rbank_d;
  logic [1:0]      full_q, full_d;
  logic [1:0][7:0] line_y_q, line_y_d;
  logic            row_q, row_d;
  logic [7:0]      col_q, col_d;
  logic [1:0]      sub_q, sub_d;
  logic [23:0]     rowstart_q, rowstart_d;
  logic [23:0]     addr_q, addr_d;
  logic            overrun_q, overrun_d;
  logic [15:0]     rd_q;
  logic [15:0]     lbuf [512];

  logic            pix_acc;
  logic            line_done;
  logic            emit_last;
  logic            other_free;
  logic            drop;
  logic [23:0]     rs;
  logic [15:0]     pix_565;

  // Pixel acceptance, line completion and drop decision
  always_comb begin
    pix_acc    = en & pix_we & (pix_x < 9'd256) & (pix_y < 9'd240);
    line_done  = pix_acc & (pix_x[7:0] == 8'hff);
    pix_565    = {pix_rgb[23:19], pix_rgb[15:10], pix_rgb[7:3]};
    emit_last  = (state_q == EMIT) & out_rdy & (sub_q == 2'd2) & (col_q == 8'hff) & row_q;
    // A bank freed by the emitter this very cycle counts as free
    other_free = ~full_q[~wbank_q] | (emit_last & (rbank_q == ~wbank_q));
    drop       = line_done & ~other_free;
  end

  // Row start address: y * 2 * WIDTH built as a sum of shifted strides
  always_comb begin
    rs = BASE + MARGIN;
    for (int i = 0; i < 8; i++) begin
      if (line_y_q[rbank_q][i]) rs = rs + (STRIDE << i);
    end
  end

  // Line buffer write port, indexed by the capture bank
  always_ff @(posedge clk) begin
    if (pix_acc) lbuf[{wbank_q, pix_x[7:0]}] <= pix_565;
  end

  // Registered line buffer read, loaded in FETCH and held through EMIT
  always_ff @(posedge clk) begin
    if (reset) rd_q <= '0;
    else if (state_q == FETCH) rd_q <= lbuf[{rbank_q, col_q}];
  end

  // Emitter next state plus bank bookkeeping
  always_comb begin
    state_d    = state_q;
    wbank_d    = wbank_q;
    rbank_d    = rbank_q;
    full_d     = full_q;
    line_y_d   = line_y_q;
    row_d      = row_q;
    col_d      = col_q;
    sub_d      = sub_q;
    rowstart_d = rowstart_q;
    addr_d     = addr_q;
    overrun_d  = drop ? 1'b1 : (clr ? 1'b0 : overrun_q);

    case (state_q)
      IDLE: begin
        if (full_q[rbank_q]) state_d = LOAD;
      end
      LOAD: begin
        row_d      = 1'b0;
        col_d      = 8'd0;
        sub_d      = 2'd0;
        rowstart_d = rs;
        addr_d     = rs;
        state_d    = FETCH;
      end
      FETCH: begin
        state_d = EMIT;
      end
      EMIT: begin
        if (out_rdy) begin
          addr_d = addr_q + 24'd1;
          if (sub_q != 2'd2) begin
            sub_d = sub_q + 2'd1;
          end else if (col_q != 8'hff) begin
            sub_d   = 2'd0;
            col_d   = col_q + 8'd1;
            state_d = FETCH;
          end else if (!row_q) begin
            row_d   = 1'b1;
            col_d   = 8'd0;
            sub_d   = 2'd0;
            addr_d  = rowstart_q + PITCH;
            state_d = FETCH;
          end else begin
            rbank_d = ~rbank_q;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (emit_last) full_d[rbank_q] = 1'b0;
    if (line_done && other_free) begin
      full_d[wbank_q]   = 1'b1;
      line_y_d[wbank_q] = pix_y[7:0];
      wbank_d           = ~wbank_q;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wbank_q    <= 1'b0;
      rbank_q    <= 1'b0;
      full_q     <= 2'b00;
      line_y_q   <= '0;
      row_q      <= 1'b0;
      col_q      <= 8'd0;
      sub_q      <= 2'd0;
      rowstart_q <= '0;
      addr_q     <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wbank_q    <= wbank_d;
      rbank_q    <= rbank_d;
      full_q     <= full_d;
      line_y_q   <= line_y_d;
      row_q      <= row_d;
      col_q      <= col_d;
      sub_q      <= sub_d;
      rowstart_q <= rowstart_d;
      addr_q     <= addr_d;
      overrun_q  <= overrun_d;
    end
  end

  // Output mapping
  always_comb begin
    out_we   = (state_q == EMIT);
    out_addr = addr_q;
    out_data = rd_q;
    frame    = emit_last & (line_y_q[rbank_q] == 8'd239);
    overrun  = overrun_q;
  end

endmodule
